// File: rtl/imem_boot_server.sv
// Boot-time program loader and zero-latency instruction server for the core fetch port.
// A host streams words in over valid/ready; once loaded, instn is served combinationally from IF_PC.
module imem_boot_server #(
  parameter int          DEPTH = 256,
  parameter int          AW    = 8,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot_req,
  input  logic          host_valid,
  input  logic [31:0]   host_data,
  input  logic          host_last,
  output logic          host_ready,
  output logic          boot_up,
  input  logic          PC_run,
  input  logic [15:0]   IF_PC,
  output logic [31:0]   instn,
  output logic [AW:0]   load_cnt,
  output logic          load_ovf
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;

  state_t      state_reg, state_next;
  logic [AW:0] cnt_reg, cnt_next;
  logic        ovf_reg, ovf_next;
  logic        ready_reg;
  logic        wr_en;
  logic        xfer;

  logic [31:0] mem [DEPTH];

  assign xfer = host_valid & ready_reg;

  // The write pointer and the stored-word count always move together, so one counter serves both.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (boot_req) begin
          state_next = LOAD;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (cnt_reg < DEPTH_W) begin
            wr_en    = 1'b1;
            cnt_next = cnt_reg + 1'b1;
          end else begin
            ovf_next = 1'b1;
          end
          if (host_last) state_next = START;
        end
      end
      START: state_next = RUN;
      RUN: begin
        if (boot_req) begin
          state_next = LOAD;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      ready_reg <= (state_next == LOAD);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_reg[AW-1:0]] <= host_data;
  end

  // Fetch path: only addresses inside the loaded program return real words.
  logic [AW-1:0] fetch_idx;
  logic          fetch_hit;

  assign fetch_idx = IF_PC[AW+1:2];
  assign fetch_hit = (state_reg == RUN) && PC_run &&
                     ((IF_PC >> (AW+2)) == 16'd0) &&
                     ({1'b0, fetch_idx} < cnt_reg);

  assign instn      = fetch_hit ? mem[fetch_idx] : NOP;
  assign host_ready = ready_reg;
  assign boot_up    = (state_reg == START);
  assign load_cnt   = cnt_reg;
  assign load_ovf   = ovf_reg;

endmodule
